// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and requantization helper
// for the first-layer CNN pooling stage.
package cnn_pkg;

    localparam int NF      = 16;
    localparam int IN_DIM  = 26;
    localparam int OUT_DIM = 13;
    localparam int SHIFT   = 8;

    typedef enum logic [1:0] {
        IDLE,
        POOL,
        FLUSH,
        DONE
    } pool_state_t;

    function automatic logic signed [7:0] sat8(input logic signed [31:0] v);
        if (v > 32'sd127) begin
            return 8'sh7f;
        end
        if (v < -32'sd128) begin
            return 8'sh80;
        end
        return v[7:0];
    endfunction

endpackage

// File: rtl/pool_max4.sv
// Combinational signed maximum of one 2x2 pooling window.
module pool_max4 (
    input  logic signed [31:0] a0,
    input  logic signed [31:0] a1,
    input  logic signed [31:0] a2,
    input  logic signed [31:0] a3,
    output logic signed [31:0] y
);

    logic signed [31:0] m01;
    logic signed [31:0] m23;

    always_comb begin
        m01 = (a0 > a1) ? a0 : a1;
        m23 = (a2 > a3) ? a2 : a3;
        y   = (m01 > m23) ? m01 : m23;
    end

endmodule

// File: rtl/maxpool1.sv
// 2x2 stride-2 max pooling with 8-bit requantization, one window per cycle,
// two-stage pipeline (window max, then shift/saturate/write).
module maxpool1
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              t,
    output logic              d,
    output logic              busy,
    input  logic signed [31:0] feature_map [NF][IN_DIM][IN_DIM],
    output logic signed [7:0]  pooled_map  [NF][OUT_DIM][OUT_DIM]
);

    localparam logic [3:0] FMAX = 4'(NF - 1);
    localparam logic [3:0] OMAX = 4'(OUT_DIM - 1);

    pool_state_t state, state_nx;

    logic [3:0] f, r, c;
    logic       last;
    logic [4:0] y0, y1, x0, x1;
    logic signed [31:0] win_max;

    logic               s1_valid;
    logic signed [31:0] s1_max;
    logic [3:0]         s1_f, s1_r, s1_c;
    logic signed [31:0] shifted;

    assign last = (f == FMAX) && (r == OMAX) && (c == OMAX);
    assign y0   = {r, 1'b0};
    assign y1   = {r, 1'b1};
    assign x0   = {c, 1'b0};
    assign x1   = {c, 1'b1};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (t) state_nx = POOL;
            POOL:    if (last) state_nx = FLUSH;
            FLUSH:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        d    = (state == DONE);
        busy = (state == POOL) || (state == FLUSH);
    end

    // Indices sit at zero outside POOL so every run starts at (0,0,0).
    always_ff @(posedge clk) begin
        if (!reset || state != POOL) begin
            f <= '0;
            r <= '0;
            c <= '0;
        end else if (c == OMAX) begin
            c <= '0;
            if (r == OMAX) begin
                r <= '0;
                f <= f + 4'd1;
            end else begin
                r <= r + 4'd1;
            end
        end else begin
            c <= c + 4'd1;
        end
    end

    pool_max4 u_max (
        .a0 (feature_map[f][y0][x0]),
        .a1 (feature_map[f][y0][x1]),
        .a2 (feature_map[f][y1][x0]),
        .a3 (feature_map[f][y1][x1]),
        .y  (win_max)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_max   <= '0;
            s1_f     <= '0;
            s1_r     <= '0;
            s1_c     <= '0;
        end else begin
            s1_valid <= (state == POOL);
            s1_max   <= win_max;
            s1_f     <= f;
            s1_r     <= r;
            s1_c     <= c;
        end
    end

    assign shifted = s1_max >>> SHIFT;

    // Output array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (reset && s1_valid) begin
            pooled_map[s1_f][s1_r][s1_c] <= sat8(shifted);
        end
    end

endmodule

// File: tb/tb_maxpool1.sv
// Directed bench for maxpool1: vector table of single-window cases plus
// timing, reset-abort and back-to-back sequences.
module tb_maxpool1;
    import cnn_pkg::*;

    logic clk;
    logic reset;
    logic t;
    logic d;
    logic busy;
    logic signed [31:0] fm [NF][IN_DIM][IN_DIM];
    logic signed [7:0]  pm [NF][OUT_DIM][OUT_DIM];

    int n_cmp;
    int n_err;
    int cyc;

    typedef struct {
        string name;
        int    f;
        int    y;
        int    x;
        int    val;
        bit    win;
        int    exp;
    } vec_t;

    vec_t vecs [11];

    maxpool1 dut (
        .clk         (clk),
        .reset       (reset),
        .t           (t),
        .d           (d),
        .busy        (busy),
        .feature_map (fm),
        .pooled_map  (pm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_map();
        for (int i = 0; i < NF; i++)
            for (int j = 0; j < IN_DIM; j++)
                for (int k = 0; k < IN_DIM; k++)
                    fm[i][j][k] = 0;
    endtask

    task automatic ramp_map();
        for (int i = 0; i < NF; i++)
            for (int j = 0; j < IN_DIM; j++)
                for (int k = 0; k < IN_DIM; k++)
                    fm[i][j][k] = 256 * (i + j + k);
    endtask

    // Start one run and time d/busy relative to E0.
    task automatic run(output int dcyc, output int bcyc, output int dlen);
        dcyc = -1;
        bcyc = 0;
        dlen = 0;
        @(negedge clk);
        t = 1'b1;
        @(posedge clk);
        #1 t = 1'b0;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            if (busy) bcyc++;
            if (d) begin
                dcyc = n;
                break;
            end
        end
        if (dcyc > 0) begin
            dlen = 1;
            @(negedge clk);
            if (d) dlen++;
        end
    endtask

    task automatic check_single(input string name, input int f, input int r,
                                input int c, input int exp);
        int bad;
        bad = 0;
        chk({name, " target"}, int'(pm[f][r][c]), exp);
        for (int i = 0; i < NF; i++)
            for (int j = 0; j < OUT_DIM; j++)
                for (int k = 0; k < OUT_DIM; k++)
                    if (!(i == f && j == r && k == c) && pm[i][j][k] != 0)
                        bad++;
        chk({name, " others nonzero"}, bad, 0);
    endtask

    task automatic check_ramp(input string name);
        int bad;
        int e;
        bad = 0;
        for (int i = 0; i < NF; i++)
            for (int j = 0; j < OUT_DIM; j++)
                for (int k = 0; k < OUT_DIM; k++) begin
                    e = i + 2 * j + 2 * k + 2;
                    if (e > 127) e = 127;
                    if (int'(pm[i][j][k]) != e) bad++;
                end
        chk({name, " ramp entries wrong"}, bad, 0);
    endtask

    task automatic wait_d(input string name, output int at);
        at = -1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (d) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk({name, " d timeout"}, 0, 1);
    endtask

    initial begin
        int dc, bc, dl, bad;
        int d1, d2, d3;

        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        t     = 1'b0;
        reset = 1'b0;
        clear_map();

        vecs[0]  = '{"pos clamp",   3, 24, 24, 40000,        1'b0, 127};
        vecs[1]  = '{"neg clamp",   5, 10,  7, -40000,       1'b1, -128};
        vecs[2]  = '{"trunc 255",   0,  1,  1, 255,          1'b0, 0};
        vecs[3]  = '{"exact 256",   1,  2,  3, 256,          1'b0, 1};
        vecs[4]  = '{"edge 127",   15, 25,  0, 32767,        1'b0, 127};
        vecs[5]  = '{"sat 128",     7, 13, 12, 32768,        1'b0, 127};
        vecs[6]  = '{"neg -1",      2,  4,  4, -256,         1'b1, -1};
        vecs[7]  = '{"neg -128",    9,  0, 25, -32768,       1'b1, -128};
        vecs[8]  = '{"neg -129",    4,  6,  6, -32769,       1'b1, -128};
        vecs[9]  = '{"floor -1",    8, 20, 20, -1,           1'b1, -1};
        vecs[10] = '{"max int",     6, 11, 11, 32'h7fffffff, 1'b0, 127};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset d", int'(d), 0);
        chk("reset busy", int'(busy), 0);

        reset = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (d || busy) bad++;
        end
        chk("idle no activity", bad, 0);

        // Mixed window at the origin.
        clear_map();
        fm[0][0][0] = 100;
        fm[0][0][1] = 5000;
        fm[0][1][0] = 300;
        fm[0][1][1] = 20;
        run(dc, bc, dl);
        chk("origin d cycle", dc, 2706);
        check_single("origin", 0, 0, 0, 19);

        foreach (vecs[i]) begin
            clear_map();
            if (vecs[i].win) begin
                for (int a = 0; a < 2; a++)
                    for (int b = 0; b < 2; b++)
                        fm[vecs[i].f][(vecs[i].y & ~1) + a][(vecs[i].x & ~1) + b]
                            = vecs[i].val;
            end else begin
                fm[vecs[i].f][vecs[i].y][vecs[i].x] = vecs[i].val;
            end
            run(dc, bc, dl);
            chk({vecs[i].name, " d cycle"}, dc, 2706);
            check_single(vecs[i].name, vecs[i].f, vecs[i].y / 2,
                         vecs[i].x / 2, vecs[i].exp);
        end

        // Full ramp run with timing.
        ramp_map();
        run(dc, bc, dl);
        chk("ramp d cycle", dc, 2706);
        chk("ramp busy cycles", bc, 2705);
        chk("ramp d width", dl, 1);
        check_ramp("ramp");

        // Abort mid-run, then a clean run with different data.
        clear_map();
        @(negedge clk);
        t = 1'b1;
        @(posedge clk);
        #1 t = 1'b0;
        repeat (999) @(negedge clk);
        chk("abort busy before", int'(busy), 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort d", int'(d), 0);
        @(negedge clk);
        reset = 1'b1;
        ramp_map();
        run(dc, bc, dl);
        chk("post-abort d cycle", dc, 2706);
        chk("post-abort busy cycles", bc, 2705);
        check_ramp("post-abort");

        // Back-to-back with t held, plus a t toggle inside POOL.
        @(negedge clk);
        t = 1'b1;
        wait_d("b2b first", d1);
        wait_d("b2b second", d2);
        repeat (500) @(negedge clk);
        t = 1'b0;
        repeat (3) @(negedge clk);
        t = 1'b1;
        wait_d("b2b third", d3);
        t = 1'b0;
        chk("b2b period", d2 - d1, 2707);
        chk("b2b toggle period", d3 - d2, 2707);
        repeat (3) @(negedge clk);
        chk("b2b idle after", int'(busy), 0);
        check_ramp("b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/maxpool1.md
# maxpool1

- Downstream stage of the first convolution layer.
- Consumes the 16×26×26 ReLU'd 32-bit feature map and performs 2×2 stride-2 max pooling.
- Requantizes each pooled value to signed 8-bit by arithmetic shift and saturation.
- Produces a 16×13×13 map in the format the next convolution layer takes as `input_image`-style 8-bit data, and uses the same `t`/`d` start/done handshake as the convolution layers.

## Interface
- `NF`, 16, number of feature maps.
- `IN_DIM`, 26, input map height and width.
- `OUT_DIM`, 13, output map height and width (`IN_DIM/2`).
- `SHIFT`, 8, requantization right-shift amount.
- `clk`  input  1  single clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `t`  input  1  start trigger; sampled only in IDLE.
- `d`  output  1  done; one-cycle pulse.
- `busy`  output  1  high while windows are being processed (POOL or FLUSH).
- `feature_map`  input  signed 32 × [NF][IN_DIM][IN_DIM]  conv output; must be stable while `busy`.
- `pooled_map`  output  signed 8 × [NF][OUT_DIM][OUT_DIM]  registered pooled, requantized result.

## Operation
- States:
  - IDLE → POOL when `t`=1.
  - POOL → FLUSH after the window at (f,r,c)=(NF-1,OUT_DIM-1,OUT_DIM-1) is issued.
  - FLUSH → DONE unconditionally.
  - DONE → IDLE unconditionally.
- Index order is filter-major: c increments fastest (0..12), then r, then f. Indices reset to 0 on entering POOL.
- Stage 1 (each POOL cycle):
  - Window: `feature_map[f][2r..2r+1][2c..2c+1]`.
  - Register its signed maximum plus (f,r,c) and a valid bit.
- Stage 2 (cycle after a valid stage-1 entry):
  - `v = max >>> SHIFT` (arithmetic shift, truncation toward −∞).
  - Clamp `v` to [−128, 127].
  - Write the result to `pooled_map[f][r][c]`.
- FLUSH exists only to drain stage 2; no new window is issued.
- `t` is ignored in POOL, FLUSH and DONE. If `t` is still high in IDLE, a new run starts immediately.
- Reset (low at an edge), including mid-operation:
  - state=IDLE, f/r/c=0, pipeline valid=0, `d`=0, `busy`=0.
  - `pooled_map` is not reset; it keeps prior contents, and a partially written run is left as is.
- Ties in the max are irrelevant (equal values). Compare as signed 32-bit. Inputs are ≥0 after ReLU, but negative inputs must still pool and clamp correctly.

## Timing
- Throughput: one window per cycle. `NF·OUT_DIM²` = 2704 POOL cycles.
- Edge E0 is the edge at which `t`=1 is sampled in IDLE. Then:
  - POOL occupies cycles 1–2704 after E0.
  - FLUSH occupies cycle 2705.
  - DONE occupies cycle 2706.
- `d`=1 only in DONE. All of `pooled_map` is valid from the DONE cycle onward.
- `busy`=1 for exactly 2705 cycles (POOL+FLUSH).
- Back-to-back runs with `t` held high: period 2707 cycles (includes one IDLE cycle).
- Latency from a window issue to its `pooled_map` update is 1 cycle. The write is visible on the second edge after the issue.
- Outputs after reset: `d`=0 and `busy`=0, effective at the reset edge.

## Structure
- Shared package `cnn_pkg` holds:
  - `NF`/dimension constants.
  - `SHIFT`.
  - state enum `pool_state_t` {IDLE, POOL, FLUSH, DONE}.
  - function `sat8(logic signed [31:0])`.
- Sub-module `pool_max4`: combinational signed 4-input max, 32-bit in and out; one instance.
- Top holds the FSM, index counters, the two pipeline registers and the output array.

## Test plan
- Reset with `t`=0 → `d`=0, `busy`=0. After reset release with no `t`, still `d`=0, `busy`=0 for 100 cycles.
- `feature_map[0][0..1][0..1]` = {100, 5000, 300, 20}, all else 0, one run → `pooled_map[0][0][0]`=19 and every other entry 0.
- `feature_map[3][24][24]`=40000 (others 0) → `pooled_map[3][12][12]`=127. A value of −40000 in an all-negative window → −128.
- Full run with `feature_map[f][y][x]` = 256·(f+y+x) → `d` pulses exactly 2706 cycles after E0 for one cycle, `busy` is high for 2705 cycles, and `pooled_map[f][r][c]` = min(127, f+2r+2c+2).
- Reset asserted at cycle 1000 of a run → `busy`/`d` low at that edge. A fresh `t` then completes with `d` 2706 cycles later and correct contents.
- `t` held high across two runs → `d` pulses 2707 cycles apart. A `t` toggle during POOL has no effect on timing.
